// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_defs
// Description : Shared encodings for the multi-cycle MIPS controller: ALU ops,
//               opcode/funct values, mux selects, FSM states and the
//               instruction-class one-hot used between decode and FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

   // ALU operation codes
   localparam logic [2:0] ALU_ADDU = 3'b000;
   localparam logic [2:0] ALU_SUBU = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_LUI  = 3'b100;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;

   // Next-PC select
   localparam logic [1:0] NPC_PC4    = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_REG    = 2'b11;

   // Register destination select
   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   // Write-data select
   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC4 = 2'b10;

   // FSM states
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM_RD = 3'd3;
   localparam logic [2:0] S_MEM_WR = 3'd4;
   localparam logic [2:0] S_WB_ALU = 3'd5;
   localparam logic [2:0] S_WB_MEM = 3'd6;
   localparam logic [2:0] S_HALT   = 3'd7;

   // Instruction-class one-hot bit positions; classes 0..6 need S_EXEC
   localparam int CLS_ADDU = 0;
   localparam int CLS_SUBU = 1;
   localparam int CLS_ORI  = 2;
   localparam int CLS_LUI  = 3;
   localparam int CLS_LW   = 4;
   localparam int CLS_SW   = 5;
   localparam int CLS_BEQ  = 6;
   localparam int CLS_J    = 7;
   localparam int CLS_JAL  = 8;
   localparam int CLS_JR   = 9;
   localparam int CLS_NOP  = 10;
   localparam int CLS_W    = 11;

   typedef logic [CLS_W-1:0] cls_t;

   localparam cls_t CLS_EXEC_MASK = 11'b000_0111_1111;

   // ALU-side control word shared by EXEC and the states that hold it
   typedef struct packed {
      logic [2:0] op;
      logic       srcb;
      logic       ext;
   } alu_ctl_t;

   // ALU op / operand-B source / extender mode for an instruction class
   function automatic alu_ctl_t alu_ctl_of(input cls_t cls);
      alu_ctl_t c;
      c.op   = ALU_ADDU;
      c.srcb = 1'b0;
      c.ext  = 1'b0;
      if (cls[CLS_SUBU] || cls[CLS_BEQ]) c.op = ALU_SUBU;
      if (cls[CLS_ORI]) begin
         c.op   = ALU_OR;
         c.srcb = 1'b1;
      end
      if (cls[CLS_LUI]) begin
         c.op   = ALU_LUI;
         c.srcb = 1'b1;
      end
      if (cls[CLS_LW] || cls[CLS_SW]) begin
         c.srcb = 1'b1;
         c.ext  = 1'b1;
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational opcode/funct decoder producing an
//               instruction-class one-hot and an illegal-instruction flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
   import mips_defs::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output cls_t       cls,
   output logic       illegal
);

   // Map each supported encoding to exactly one class bit
   always_comb begin
      cls = '0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: cls[CLS_ADDU] = 1'b1;
               FN_SUBU: cls[CLS_SUBU] = 1'b1;
               FN_JR:   cls[CLS_JR]   = 1'b1;
               FN_SLL:  cls[CLS_NOP]  = 1'b1;
               default: cls = '0;
            endcase
         end
         OP_ORI:  cls[CLS_ORI] = 1'b1;
         OP_LUI:  cls[CLS_LUI] = 1'b1;
         OP_LW:   cls[CLS_LW]  = 1'b1;
         OP_SW:   cls[CLS_SW]  = 1'b1;
         OP_BEQ:  cls[CLS_BEQ] = 1'b1;
         OP_J:    cls[CLS_J]   = 1'b1;
         OP_JAL:  cls[CLS_JAL] = 1'b1;
         default: cls = '0;
      endcase
      illegal = (cls == '0);
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Main control FSM of the multi-cycle MIPS datapath. Steps each
//               instruction through fetch/decode/execute/memory/writeback and
//               emits the per-state control word; memories are handshaked.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
   import mips_defs::*;
#(
   parameter int         IMEM_TIMEOUT = 0,
   parameter logic [1:0] RESET_PC_SEL = 2'b11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       pc_we,
   output logic       ir_we,
   output logic [1:0] npc_sel,
   output logic       reg_we,
   output logic [1:0] reg_dst,
   output logic [1:0] wd_sel,
   output logic       alu_srcb,
   output logic       ext_op,
   output logic [2:0] alu_op,
   output logic       retire,
   output logic       fault,
   output logic [2:0] state_o
);

   logic [2:0] state_q, state_d;
   logic       fault_q, fault_d;
   cls_t       cls;
   logic       illegal;
   logic       timeout;
   alu_ctl_t   alu_ctl;

   ctrl_decode u_decode (
      .opcode  (opcode),
      .funct   (funct),
      .cls     (cls),
      .illegal (illegal)
   );

   assign alu_ctl = alu_ctl_of(cls);

   generate
      if (IMEM_TIMEOUT > 0) begin : g_timeout
         localparam int CW = $clog2(IMEM_TIMEOUT + 1);
         logic [CW-1:0] wait_q, wait_d;

         // Count consecutive unanswered fetch cycles; any other state clears it
         always_comb begin
            wait_d = '0;
            if (state_q == S_FETCH && !imem_ready) wait_d = wait_q + 1'b1;
         end

         // Wait counter register
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) wait_q <= '0;
            else        wait_q <= wait_d;
         end

         // The current unanswered cycle is the N-th one
         assign timeout = (state_q == S_FETCH) && !imem_ready &&
                          (wait_q == CW'(IMEM_TIMEOUT - 1));
      end else begin : g_no_timeout
         assign timeout = 1'b0;
      end
   endgenerate

   // State and sticky fault registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) begin
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end
         end
         S_DECODE: begin
            if (illegal) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end else if ((cls & CLS_EXEC_MASK) != '0) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            if (cls[CLS_LW])       state_d = S_MEM_RD;
            else if (cls[CLS_SW])  state_d = S_MEM_WR;
            else if (cls[CLS_BEQ]) state_d = S_FETCH;
            else                   state_d = S_WB_ALU;
         end
         S_MEM_RD: if (dmem_ready) state_d = S_WB_MEM;
         S_MEM_WR: if (dmem_ready) state_d = S_FETCH;
         S_WB_ALU: state_d = S_FETCH;
         S_WB_MEM: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   // Control-word table; forced idle while reset is held so requests drop at once
   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      pc_we    = 1'b0;
      ir_we    = 1'b0;
      npc_sel  = NPC_PC4;
      reg_we   = 1'b0;
      reg_dst  = RD_RT;
      wd_sel   = WD_ALU;
      alu_srcb = 1'b0;
      ext_op   = 1'b0;
      alu_op   = ALU_ADDU;
      retire   = 1'b0;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            S_DECODE: begin
               if (cls[CLS_J]) begin
                  pc_we   = 1'b1;
                  npc_sel = NPC_JUMP;
                  retire  = 1'b1;
               end else if (cls[CLS_JAL]) begin
                  pc_we   = 1'b1;
                  npc_sel = NPC_JUMP;
                  reg_we  = 1'b1;
                  reg_dst = RD_RA;
                  wd_sel  = WD_PC4;
                  retire  = 1'b1;
               end else if (cls[CLS_JR]) begin
                  pc_we   = 1'b1;
                  npc_sel = NPC_REG;
                  retire  = 1'b1;
               end else if (cls[CLS_NOP]) begin
                  retire  = 1'b1;
               end
            end
            S_EXEC: begin
               {alu_op, alu_srcb, ext_op} = alu_ctl;
               if (cls[CLS_BEQ]) begin
                  pc_we   = zero;
                  npc_sel = NPC_BRANCH;
                  retire  = 1'b1;
               end
            end
            S_MEM_RD: begin
               {alu_op, alu_srcb, ext_op} = alu_ctl;
               dmem_req = 1'b1;
            end
            S_MEM_WR: begin
               {alu_op, alu_srcb, ext_op} = alu_ctl;
               dmem_req = 1'b1;
               dmem_we  = 1'b1;
               retire   = dmem_ready;
            end
            S_WB_ALU: begin
               {alu_op, alu_srcb, ext_op} = alu_ctl;
               reg_we  = 1'b1;
               wd_sel  = WD_ALU;
               reg_dst = (cls[CLS_ADDU] || cls[CLS_SUBU]) ? RD_RD : RD_RT;
               retire  = 1'b1;
            end
            S_WB_MEM: begin
               reg_we  = 1'b1;
               wd_sel  = WD_MEM;
               reg_dst = RD_RT;
               retire  = 1'b1;
            end
            // Park the PC mux on the recovery vector while halted
            S_HALT:  npc_sel = RESET_PC_SEL;
            default: npc_sel = NPC_PC4;
         endcase
      end
   end

   assign fault   = fault_q;
   assign state_o = state_q;

endmodule
`default_nettype wire
